sram_port_arbiter: RTL and testbench

//  Shares one synchronous SRAM port (addra/dina/douta/ena/wea, 1-cycle read latency) between two

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_port_arbiter_rr_pick2.sv | 35 +++
 rtl/sram_port_arbiter.sv | 110 +++++++++++
 tb/tb_sram_port_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types for the data-side SRAM port arbiter: master ids and the
// request bundle at the default bus widths.
package sram_pkg;

  localparam int SRAM_ADDR_W = 64;
  localparam int SRAM_DATA_W = 64;
  localparam int SRAM_STRB_W = SRAM_DATA_W / 8;

  typedef struct packed {
    logic [SRAM_ADDR_W-1:0] addr;
    logic [SRAM_DATA_W-1:0] wdata;
    logic [SRAM_STRB_W-1:0] wstrb;
  } sram_req_t;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

  function automatic master_id_e other_master(input master_id_e m);
    return (m == M0) ? M1 : M0;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr_pick2.sv
// Two-way round-robin pick with a hold limit; purely combinational, the
// history registers live in the caller.
module rr_pick2
  import sram_pkg::*;
#(
  parameter int MAX_HOLD = 4,
  parameter int HOLD_W   = $clog2(MAX_HOLD + 1)
) (
  input  logic [1:0]        req,
  input  master_id_e        last_winner,
  input  logic [HOLD_W-1:0] hold_cnt,
  output logic [1:0]        gnt
);

  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  logic       keep;
  master_id_e winner;

  // A zero count means the streak was broken (idle or reset), so the other
  // master gets the next contest; this is what hands M0 the first one.
  assign keep = (hold_cnt != '0) && (hold_cnt < HOLD_LIM);

  always_comb begin
    gnt    = 2'b00;
    winner = keep ? last_winner : other_master(last_winner);
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (winner == M1) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 1-cycle-latency SRAM port between the pipeline data port (M0)
// and a secondary master (M1), routing read data back to the issuing master.
module sram_port_arbiter
  import sram_pkg::*;
#(
  parameter int LEN_ADDR = 64,
  parameter int LEN_DATA = 64,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m0_req,
  input  logic [LEN_ADDR-1:0]   m0_addr,
  input  logic [LEN_DATA-1:0]   m0_wdata,
  input  logic [LEN_DATA/8-1:0] m0_wstrb,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [LEN_DATA-1:0]   m0_rdata,
  input  logic                  m1_req,
  input  logic [LEN_ADDR-1:0]   m1_addr,
  input  logic [LEN_DATA-1:0]   m1_wdata,
  input  logic [LEN_DATA/8-1:0] m1_wstrb,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [LEN_DATA-1:0]   m1_rdata,
  output logic [LEN_ADDR-1:0]   s_addra,
  output logic [LEN_DATA-1:0]   s_dina,
  output logic                  s_ena,
  output logic [LEN_DATA/8-1:0] s_wea,
  input  logic [LEN_DATA-1:0]   s_douta
);

  localparam int LEN_STRB = LEN_DATA / 8;
  localparam int HOLD_W   = $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              any_gnt;
  logic              is_read;
  master_id_e        cur_winner;
  master_id_e        last_winner;
  master_id_e        rd_owner;
  logic [HOLD_W-1:0] hold_cnt;
  logic              rd_pend;

  // Masking with rstn keeps the port quiet for the whole reset window.
  assign req = {m1_req, m0_req} & {2{rstn}};

  rr_pick2 #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_pick (
    .req         (req),
    .last_winner (last_winner),
    .hold_cnt    (hold_cnt),
    .gnt         (gnt)
  );

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign any_gnt    = |gnt;
  assign cur_winner = gnt[1] ? M1 : M0;

  always_comb begin
    s_ena   = any_gnt;
    s_addra = '0;
    s_dina  = '0;
    s_wea   = '0;
    if (gnt[0]) begin
      s_addra = m0_addr;
      s_dina  = m0_wdata;
      s_wea   = m0_wstrb;
    end else if (gnt[1]) begin
      s_addra = m1_addr;
      s_dina  = m1_wdata;
      s_wea   = m1_wstrb;
    end
  end

  assign is_read = any_gnt && (s_wea == LEN_STRB'(0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_winner <= M1;
      hold_cnt    <= '0;
      rd_pend     <= 1'b0;
      rd_owner    <= M0;
    end else begin
      rd_pend <= is_read;
      if (any_gnt) begin
        rd_owner    <= cur_winner;
        last_winner <= cur_winner;
        if (cur_winner != last_winner) begin
          hold_cnt <= HOLD_W'(1);
        end else if (hold_cnt != HOLD_LIM) begin
          hold_cnt <= hold_cnt + HOLD_W'(1);
        end
      end else begin
        hold_cnt <= '0;
      end
    end
  end

  assign m0_rvalid = rd_pend && (rd_owner == M0);
  assign m1_rvalid = rd_pend && (rd_owner == M1);
  assign m0_rdata  = m0_rvalid ? s_douta : '0;
  assign m1_rdata  = m1_rvalid ? s_douta : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: two instances (MAX_HOLD 4 and 1), each with
// its own SRAM, checked against a streak/queue reference model.
module tb_sram_port_arbiter;
  import sram_pkg::*;

  logic clk;
  logic rstn;

  sram_req_t   rq   [2][2];
  logic        rq_v [2][2];

  logic        m0_gnt [2], m1_gnt [2], m0_rvalid [2], m1_rvalid [2], s_ena [2];
  logic [63:0] m0_rdata [2], m1_rdata [2], s_addra [2], s_dina [2];
  logic [7:0]  s_wea [2];
  logic [63:0] douta0, douta1;

  logic [63:0] mem0 [32];
  logic [63:0] mem1 [32];
  logic [63:0] pre_img [32];
  logic        pre_we;

  int n_tests, n_fail;

  int          exp_g    [2];
  int          last_w   [2];
  int          streak   [2];
  bit          pend_v   [2];
  int          pend_own [2];
  logic [63:0] pend_dat [2];
  logic [63:0] ref_mem  [2][32];

  sram_port_arbiter #(.LEN_ADDR(64), .LEN_DATA(64), .MAX_HOLD(4)) dut_h4 (
    .clk(clk), .rstn(rstn),
    .m0_req(rq_v[0][0]), .m0_addr(rq[0][0].addr), .m0_wdata(rq[0][0].wdata), .m0_wstrb(rq[0][0].wstrb),
    .m0_gnt(m0_gnt[0]), .m0_rvalid(m0_rvalid[0]), .m0_rdata(m0_rdata[0]),
    .m1_req(rq_v[0][1]), .m1_addr(rq[0][1].addr), .m1_wdata(rq[0][1].wdata), .m1_wstrb(rq[0][1].wstrb),
    .m1_gnt(m1_gnt[0]), .m1_rvalid(m1_rvalid[0]), .m1_rdata(m1_rdata[0]),
    .s_addra(s_addra[0]), .s_dina(s_dina[0]), .s_ena(s_ena[0]), .s_wea(s_wea[0]), .s_douta(douta0)
  );

  sram_port_arbiter #(.LEN_ADDR(64), .LEN_DATA(64), .MAX_HOLD(1)) dut_h1 (
    .clk(clk), .rstn(rstn),
    .m0_req(rq_v[1][0]), .m0_addr(rq[1][0].addr), .m0_wdata(rq[1][0].wdata), .m0_wstrb(rq[1][0].wstrb),
    .m0_gnt(m0_gnt[1]), .m0_rvalid(m0_rvalid[1]), .m0_rdata(m0_rdata[1]),
    .m1_req(rq_v[1][1]), .m1_addr(rq[1][1].addr), .m1_wdata(rq[1][1].wdata), .m1_wstrb(rq[1][1].wstrb),
    .m1_gnt(m1_gnt[1]), .m1_rvalid(m1_rvalid[1]), .m1_rdata(m1_rdata[1]),
    .s_addra(s_addra[1]), .s_dina(s_dina[1]), .s_ena(s_ena[1]), .s_wea(s_wea[1]), .s_douta(douta1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAMs: 32 x 64b, word index from addr[7:3], 1-cycle read.
  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 32; i++) mem0[i] <= pre_img[i];
    end else if (s_ena[0]) begin
      douta0 <= mem0[s_addra[0][7:3]];
      for (int b = 0; b < 8; b++)
        if (s_wea[0][b]) mem0[s_addra[0][7:3]][8*b +: 8] <= s_dina[0][8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (pre_we) begin
      for (int i = 0; i < 32; i++) mem1[i] <= pre_img[i];
    end else if (s_ena[1]) begin
      douta1 <= mem1[s_addra[1][7:3]];
      for (int b = 0; b < 8; b++)
        if (s_wea[1][b]) mem1[s_addra[1][7:3]][8*b +: 8] <= s_dina[1][8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int hold_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // Expected winner: sole requester wins; in a contest the last winner keeps
  // the port only while its running streak is non-zero and below the limit.
  function automatic int pick(input int d);
    bit r0, r1;
    r0 = rq_v[d][0];
    r1 = rq_v[d][1];
    if (!rstn) return -1;
    if (r0 && r1) return (streak[d] > 0 && streak[d] < hold_of(d)) ? last_w[d] : 1 - last_w[d];
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset(input int d);
    last_w[d] = 1;
    streak[d] = 0;
    pend_v[d] = 1'b0;
  endtask

  task automatic model_tick();
    int g, idx;
    for (int d = 0; d < 2; d++) begin
      if (!rstn) begin
        model_reset(d);
      end else begin
        g = exp_g[d];
        if (g < 0) begin
          streak[d] = 0;
          pend_v[d] = 1'b0;
        end else begin
          if (g == last_w[d]) streak[d] = (streak[d] < hold_of(d)) ? streak[d] + 1 : hold_of(d);
          else streak[d] = 1;
          last_w[d] = g;
          idx = int'(rq[d][g].addr[7:3]);
          if (rq[d][g].wstrb == 8'h00) begin
            pend_v[d]   = 1'b1;
            pend_own[d] = g;
            pend_dat[d] = ref_mem[d][idx];
          end else begin
            pend_v[d] = 1'b0;
            for (int b = 0; b < 8; b++)
              if (rq[d][g].wstrb[b]) ref_mem[d][idx][8*b +: 8] = rq[d][g].wdata[8*b +: 8];
          end
        end
      end
    end
  endtask

  task automatic compare_dut(input int d);
    int g;
    logic [63:0] ea, ed;
    logic [7:0]  ew;
    bit rv0, rv1;
    g = pick(d);
    exp_g[d] = g;
    ea = '0; ed = '0; ew = '0;
    if (g >= 0) begin
      ea = rq[d][g].addr;
      ed = rq[d][g].wdata;
      ew = rq[d][g].wstrb;
    end
    rv0 = pend_v[d] && pend_own[d] == 0;
    rv1 = pend_v[d] && pend_own[d] == 1;
    check($sformatf("d%0d_gnt", d), 64'({m1_gnt[d], m0_gnt[d]}), (g < 0) ? 64'd0 : (g == 1 ? 64'd2 : 64'd1));
    check($sformatf("d%0d_ena", d), 64'(s_ena[d]), 64'(g >= 0));
    check($sformatf("d%0d_addra", d), s_addra[d], ea);
    check($sformatf("d%0d_dina", d), s_dina[d], ed);
    check($sformatf("d%0d_wea", d), 64'(s_wea[d]), 64'(ew));
    check($sformatf("d%0d_m0_rvalid", d), 64'(m0_rvalid[d]), 64'(rv0));
    check($sformatf("d%0d_m1_rvalid", d), 64'(m1_rvalid[d]), 64'(rv1));
    check($sformatf("d%0d_m0_rdata", d), m0_rdata[d], rv0 ? pend_dat[d] : 64'd0);
    check($sformatf("d%0d_m1_rdata", d), m1_rdata[d], rv1 ? pend_dat[d] : 64'd0);
  endtask

  task automatic step();
    #1;
    for (int d = 0; d < 2; d++) compare_dut(d);
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic set_req(input int d, input int m, input bit v, input logic [63:0] a,
                         input logic [63:0] wd, input logic [7:0] ws);
    rq_v[d][m]     = v;
    rq[d][m].addr  = a;
    rq[d][m].wdata = wd;
    rq[d][m].wstrb = ws;
  endtask

  task automatic new_req(input int d, input int m);
    logic [63:0] a;
    logic [7:0]  ws;
    a  = {56'd0, 5'($urandom_range(0, 31)), 3'b000};
    ws = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
    set_req(d, m, $urandom_range(0, 3) != 0, a, {$urandom, $urandom}, ws);
  endtask

  task automatic rand_read(input int d, input int m);
    set_req(d, m, 1'b1, {56'd0, 5'($urandom_range(0, 31)), 3'b000}, {$urandom, $urandom}, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 32; i++) pre_img[i] = (i == 2) ? 64'hDEAD : {$urandom, $urandom};
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) ref_mem[d][i] = pre_img[i];
      model_reset(d);
      exp_g[d]    = -1;
      pend_own[d] = 0;
      pend_dat[d] = '0;
      rand_read(d, 0);
      rand_read(d, 1);
    end
    pre_we = 1'b1;
    rstn   = 1'b0;

    // Reset with both requesting: nothing may reach the SRAM.
    step();
    pre_we = 1'b0;
    step();

    // Release with both reading every cycle: M0 wins first, then the
    // hold-limited pattern (4/4 for dut_h4, alternation for dut_h1).
    rstn = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      for (int d = 0; d < 2; d++)
        check($sformatf("d%0d_pattern%0d", d, i), 64'({m1_gnt[d], m0_gnt[d]}),
              ((((d == 0) ? i / 4 : i) % 2) == 1) ? 64'd2 : 64'd1);
      step();
      for (int d = 0; d < 2; d++) begin
        rand_read(d, 0);
        rand_read(d, 1);
      end
    end

    for (int d = 0; d < 2; d++) begin
      rq_v[d][0] = 1'b0;
      rq_v[d][1] = 1'b0;
    end
    step();

    // Solo M1 read of 0x10 returns 0xDEAD the next cycle.
    for (int d = 0; d < 2; d++) set_req(d, 1, 1'b1, 64'h10, 64'd0, 8'h00);
    step();
    for (int d = 0; d < 2; d++) rq_v[d][1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_solo_rvalid", d), 64'(m1_rvalid[d]), 64'd1);
      check($sformatf("d%0d_solo_rdata", d), m1_rdata[d], 64'hDEAD);
    end
    step();

    // M0 writes 0x1122, M1 reads it back; the write yields no M0 rvalid.
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 64'h40, 64'h1122, 8'hFF);
    step();
    for (int d = 0; d < 2; d++) begin
      rq_v[d][0] = 1'b0;
      set_req(d, 1, 1'b1, 64'h40, 64'd0, 8'h00);
    end
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_wr_no_rvalid", d), 64'(m0_rvalid[d]), 64'd0);
    step();
    for (int d = 0; d < 2; d++) rq_v[d][1] = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_wr_rd_data", d), m1_rdata[d], 64'h1122);
    step();

    // Reset lands the cycle after an M0 read grant: the read is dropped.
    for (int d = 0; d < 2; d++) set_req(d, 0, 1'b1, 64'h10, 64'd0, 8'h00);
    step();
    rstn = 1'b0;
    for (int d = 0; d < 2; d++) model_reset(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d_rst_rvalid", d), 64'(m0_rvalid[d]), 64'd0);
      check($sformatf("d%0d_rst_gnt", d), 64'(m0_gnt[d]), 64'd0);
    end
    step();
    step();
    rstn = 1'b1;
    for (int d = 0; d < 2; d++) begin
      rand_read(d, 0);
      rand_read(d, 1);
    end
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d_rst_first_m0", d), 64'(m0_gnt[d]), 64'd1);
    step();

    // Random traffic; requests stay up (unchanged) until granted.
    for (int c = 0; c < 500; c++) begin
      if (!rstn) begin
        rstn = 1'b1;
      end else if ($urandom_range(0, 99) == 0) begin
        rstn = 1'b0;
        for (int d = 0; d < 2; d++) model_reset(d);
      end
      for (int d = 0; d < 2; d++)
        for (int m = 0; m < 2; m++)
          if (!rq_v[d][m] || exp_g[d] == m) new_req(d, m);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
